// File: rtl/temp_pkg.sv
// ============================================================================
//  Module      : temp_pkg
//  Description : Shared definitions for the temperature sensor reader:
//                reading width, FSM state encoding and the alert threshold
//                used by the downstream comparator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package temp_pkg;

  // Width of one sensor reading (unsigned degrees C).
  localparam int TEMP_W = 8;

  // Downstream alert fires when a reading is strictly above this value.
  localparam logic [TEMP_W-1:0] ALERT_THRESH = 8'd50;

  // Conversion sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/temp_tick_gen.sv
// ============================================================================
//  Module      : temp_tick_gen
//  Description : Half-period tick generator. While i_run is high it pulses
//                o_tick on the last cycle of every CLK_DIV-cycle window; while
//                i_run is low it holds its count at zero so that the first
//                window after i_run rises is a full CLK_DIV cycles long.
//  Ports       : clk     - system clock
//                rst_n   - asynchronous active-low reset
//                i_run   - enable counting
//                o_tick  - one-cycle pulse at end of each half-period
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module temp_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (!i_run || (r_cnt == LAST)) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tick = i_run && (r_cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/temp_sensor_reader.sv
// ============================================================================
//  Module      : temp_sensor_reader
//  Description : Periodic SPI (mode 0) reader for an 8-bit temperature sensor.
//                Every SAMPLE_PERIOD cycles (while enable is high) it drops
//                cs_n, clocks in 8 bits MSB first, and publishes the reading
//                on temperature with a one-cycle temp_valid pulse.
//                Frame: SETUP (CLK_DIV) + 8 bits (16*CLK_DIV) + HOLD (CLK_DIV).
//  Config      : `define TEMP_AVG_EN to average four conversions per output
//                (10-bit sum, temperature = sum[9:2]).
//  Ports       : clk         - system clock, rising edge
//                rst_n       - asynchronous active-low reset
//                enable      - run periodic conversions
//                miso        - serial data from sensor, MSB first
//                sclk        - serial clock, idle low
//                cs_n        - chip select, active low
//                temperature - last completed reading
//                temp_valid  - one-cycle pulse when temperature updates
//                busy        - high while cs_n is low
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module temp_sensor_reader
  import temp_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_n,
  output logic [TEMP_W-1:0] temperature,
  output logic              temp_valid,
  output logic              busy
);

  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);

  state_t            r_state;
  state_t            w_next;
  logic              w_active;
  logic              w_tick;
  logic              w_start;
  logic              w_frame_done;
  logic              w_per_done;
  logic [3:0]        r_half;
  logic [TEMP_W-1:0] r_shift;
  logic [PW-1:0]     r_per;
  logic [TEMP_W-1:0] r_temp;
  logic              r_valid;

  assign w_active = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);

  temp_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_run  (w_active),
    .o_tick (w_tick)
  );

  assign w_per_done   = (r_per == PER_LAST);
  assign w_frame_done = (r_state == HOLD) && w_tick;
  // A new conversion starts whenever the next state is SETUP coming from
  // IDLE or WAIT; the period counter is zeroed on that edge.
  assign w_start      = (w_next == SETUP) && (r_state != SETUP);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_next = SETUP;
      SETUP:   if (w_tick) w_next = SHIFT;
      SHIFT:   if (w_tick && (r_half == 4'd15)) w_next = HOLD;
      HOLD:    if (w_tick) w_next = WAIT;
      WAIT:    if (w_per_done) w_next = enable ? SETUP : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ------------------------------------------------------- period counter
  // Frozen in IDLE so it cannot wrap while conversions are stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per <= '0;
    end else if (w_start) begin
      r_per <= '0;
    end else if (r_state != IDLE) begin
      r_per <= r_per + PW'(1);
    end
  end

  // ----------------------------------------------- sclk phase / shifter
  // r_half counts sclk half-periods in SHIFT; odd values are the high phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half <= 4'd0;
    end else if (r_state != SHIFT) begin
      r_half <= 4'd0;
    end else if (w_tick) begin
      r_half <= r_half + 4'd1;
    end
  end

  // Sample on the edge where sclk goes high (end of a low half-period).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if ((r_state == SHIFT) && w_tick && !r_half[0]) begin
      r_shift <= {r_shift[TEMP_W-2:0], miso};
    end
  end

  // ------------------------------------------------------- result output
`ifdef TEMP_AVG_EN
  logic [9:0] r_acc;
  logic [1:0] r_nconv;
  logic [9:0] w_sum;

  assign w_sum = r_acc + {2'b00, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp  <= '0;
      r_valid <= 1'b0;
      r_acc   <= 10'd0;
      r_nconv <= 2'd0;
    end else begin
      r_valid <= 1'b0;
      if (w_frame_done) begin
        if (r_nconv == 2'd3) begin
          r_temp  <= w_sum[9:2];
          r_valid <= 1'b1;
          r_acc   <= 10'd0;
          r_nconv <= 2'd0;
        end else begin
          r_acc   <= w_sum;
          r_nconv <= r_nconv + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_frame_done;
      if (w_frame_done) begin
        r_temp <= r_shift;
      end
    end
  end
`endif

  // Outputs decode registered state only, so reset clears them at once.
  assign cs_n        = !w_active;
  assign busy        = w_active;
  assign sclk        = (r_state == SHIFT) && r_half[0];
  assign temperature = r_temp;
  assign temp_valid  = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_temp_sensor_reader.sv
// ============================================================================
//  Module      : tb_temp_sensor_reader
//  Description : Randomised scoreboard bench for temp_sensor_reader with an
//                SPI sensor model (drives miso on sclk falling edge).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_temp_sensor_reader;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 64;
  localparam int FRAME_CYC     = 18 * CLK_DIV;
`ifdef TEMP_AVG_EN
  localparam int EXP_VALIDS = 4;
`else
  localparam int EXP_VALIDS = 13;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       enable = 1'b0;
  logic       miso   = 1'b0;
  logic       sclk;
  logic       cs_n;
  logic [7:0] temperature;
  logic       temp_valid;
  logic       busy;

  temp_sensor_reader #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .miso        (miso),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .temperature (temperature),
    .temp_valid  (temp_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [7:0] send_q[$];   // values the sensor returns, in frame order
  logic [7:0] exp_q[$];    // scoreboard of expected published readings

  // ------------------------------------------------------- sensor model
  initial begin : sensor
    logic [7:0] cur;
    int         bi;
    int         acc;
    int         nacc;
    logic       p_cs;
    logic       p_sclk;
    cur = 8'd0; bi = -1; acc = 0; nacc = 0; p_cs = 1'b1; p_sclk = 1'b0;
    forever begin
      @(cs_n, sclk);
      if (cs_n !== p_cs) begin
        if (!cs_n) begin
          if (send_q.size() > 0) cur = send_q.pop_front();
          else cur = 8'($urandom_range(0, 255));
          miso = cur[7];
          bi   = 6;
        end else if (!rst_n) begin
          // Frame torn down by reset: nothing is published, nothing averaged.
          acc = 0; nacc = 0; bi = -1;
        end else if (bi < 0) begin
`ifdef TEMP_AVG_EN
          acc += int'(cur); nacc++;
          if (nacc == 4) begin
            exp_q.push_back(8'(acc / 4));
            acc = 0; nacc = 0;
          end
`else
          exp_q.push_back(cur);
`endif
        end
      end else if (p_sclk && !sclk && !cs_n && bi >= 0) begin
        miso = cur[bi];
        bi--;
      end
      p_cs   = cs_n;
      p_sclk = sclk;
    end
  end

  // ------------------------------------------------------------ monitor
  int         cyc = 0;
  int         n_frames = 0;
  int         n_falls = 0;
  int         n_valid = 0;
  int         low_cnt = 0;
  int         prev_fall = 0;
  bit         have_prev = 0;
  bit         gap = 1;
  logic       prev_cs = 1'b1;
  logic       prev_valid = 1'b0;
  logic [7:0] last_temp = 8'd0;

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    cyc++;
    chk("busy_vs_cs", int'(busy), int'(!cs_n));
    if (cs_n) chk("sclk_idle", int'(sclk), 0);
    if (temp_valid) begin
      chk("valid_width", int'(prev_valid), 0);
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("temperature", int'(temperature), int'(e));
      end
    end else if (rst_n) begin
      chk("temp_hold", int'(temperature), int'(last_temp));
    end
    last_temp  = temperature;
    prev_valid = temp_valid;

    if (!rst_n || !enable) gap = 1;
    if (!cs_n) low_cnt++;
    if (cs_n && !prev_cs) begin
      if (rst_n) begin
        chk("cs_low_cycles", low_cnt, FRAME_CYC);
        n_frames++;
      end
      low_cnt = 0;
    end
    if (!cs_n && prev_cs) begin
      n_falls++;
      if (have_prev && !gap) chk("setup_period", cyc - prev_fall, SAMPLE_PERIOD);
      prev_fall = cyc;
      have_prev = 1;
      gap = 0;
    end
    if (!rst_n) have_prev = 0;
    prev_cs = cs_n;
  end

  // ---------------------------------------------------- stimulus helpers
  task automatic run_frames(input int n);
    int target;
    int t;
    target = n_frames + n;
    t = 0;
    while (n_frames < target && t < (n + 2) * SAMPLE_PERIOD) begin
      @(negedge clk);
      t++;
    end
    if (n_frames < target) chk("frame_timeout", n_frames, target);
  endtask

  task automatic wait_cs_fall();
    int t;
    t = 0;
    @(negedge clk);
    while (cs_n && t < 3 * SAMPLE_PERIOD) begin
      @(negedge clk);
      t++;
    end
    if (cs_n) chk("cs_fall_timeout", int'(cs_n), 0);
  endtask

  task automatic wait_sclk_rises(input int k);
    int   seen;
    int   t;
    logic p;
    seen = 0; t = 0; p = sclk;
    while (seen < k && t < 4 * FRAME_CYC) begin
      @(negedge clk);
      if (sclk && !p) seen++;
      p = sclk;
      t++;
    end
    if (seen < k) chk("sclk_timeout", seen, k);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin : stimulus
    int falls0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cs_n", int'(cs_n), 1);
    chk("reset_sclk", int'(sclk), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(temp_valid), 0);
    chk("reset_temperature", int'(temperature), 0);
    rst_n = 1'b1;

    // Single reading, then one random frame to exercise the period.
    send_q.push_back(8'd45);
    enable = 1'b1;
    run_frames(2);

    // Around the alert threshold and the top of range.
    send_q.push_back(8'd51);
    send_q.push_back(8'd50);
    send_q.push_back(8'hFF);
    run_frames(3);

    // Random readings including the extremes.
    send_q.push_back(8'h00);
    repeat (5) send_q.push_back(8'($urandom_range(0, 255)));
    run_frames(6);

    // Enable drops during bit 3: frame completes, no further frame.
    send_q.push_back(8'd60);
    wait_cs_fall();
    wait_sclk_rises(3);
    enable = 1'b0;
    run_frames(1);
    falls0 = n_falls;
    repeat (3 * SAMPLE_PERIOD) @(negedge clk);
    chk("no_restart", n_falls - falls0, 0);
    chk("idle_busy", int'(busy), 0);

    // Reset during bit 5: frame discarded, outputs cleared immediately.
    send_q.push_back(8'd77);
`ifdef TEMP_AVG_EN
    send_q.push_back(8'd48);
    send_q.push_back(8'd52);
    send_q.push_back(8'd50);
    send_q.push_back(8'd51);
`else
    send_q.push_back(8'd30);
`endif
    enable = 1'b1;
    wait_cs_fall();
    wait_sclk_rises(5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_cs_n", int'(cs_n), 1);
    chk("midreset_sclk", int'(sclk), 0);
    chk("midreset_temperature", int'(temperature), 0);
    chk("midreset_valid", int'(temp_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
`ifdef TEMP_AVG_EN
    run_frames(4);
`else
    run_frames(1);
`endif
    enable = 1'b0;
    repeat (2 * SAMPLE_PERIOD) @(negedge clk);

    chk("pending_expected", exp_q.size(), 0);
    chk("valid_count", n_valid, EXP_VALIDS);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/temp_sensor_reader.md
TEMP_SENSOR_READER -- requirements
Module: temp_sensor_reader

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sclk half-period; legal range 1..255.
REQ-002 Parameter SAMPLE_PERIOD, default 1000: clk cycles between conversion starts; SHALL be >= 18*CLK_DIV+2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  high = periodic conversions run.
REQ-006 miso  input  1  serial data from sensor, MSB first.
REQ-007 sclk  output  1  serial clock to sensor, idle low.
REQ-008 cs_n  output  1  sensor chip select, active low.
REQ-009 temperature  output  8  last completed reading, unsigned degrees C; feeds the alert comparator unchanged.
REQ-010 temp_valid  output  1  one-cycle pulse when temperature updates.
REQ-011 busy  output  1  high while cs_n low.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, WAIT.
- IDLE -> SETUP on any cycle with enable=1.
- SETUP -> SHIFT after CLK_DIV cycles.
- SHIFT -> HOLD after 8 sclk periods.
- HOLD -> WAIT after CLK_DIV cycles.
- WAIT -> SETUP when the period counter expires and enable=1; WAIT -> IDLE when it expires and enable=0.
REQ-013 cs_n SHALL be low exactly in SETUP, SHIFT and HOLD.
REQ-014 In SHIFT each bit SHALL take 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles (SPI mode 0).
REQ-015 miso SHALL be registered in the clk cycle in which sclk rises; bits shift in MSB first; no internal synchronizer.
REQ-016 A conversion SHALL occupy exactly 18*CLK_DIV cycles of cs_n low.
REQ-017 On HOLD exit, temperature SHALL load the 8 shifted bits and temp_valid SHALL pulse high for exactly 1 cycle.
REQ-018 The period counter SHALL start at the SETUP entry cycle, so successive SETUP entries are exactly SAMPLE_PERIOD cycles apart while enable stays high.
REQ-019 enable falling mid-conversion SHALL NOT abort it: the frame completes, temperature and temp_valid update, and the FSM then returns to IDLE at period expiry.
REQ-020 temperature SHALL hold its value between updates; values 0x00 and 0xFF are legal, with no saturation or sign handling.

Reset
REQ-021 rst_n low SHALL immediately force state=IDLE, cs_n=1, sclk=0, busy=0, temp_valid=0, temperature=0, and clear all counters and the shift register.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame, and no temp_valid SHALL follow it.

Configuration
REQ-023 Macro TEMP_AVG_EN defined: four consecutive conversions accumulate into a 10-bit sum, and temperature = sum[9:2] (truncating).
- temp_valid pulses only on every 4th conversion.
- The accumulator clears after each output and on reset.
REQ-024 Macro TEMP_AVG_EN undefined: every conversion updates temperature directly, and no accumulator is synthesized.

Structure
REQ-025 Shared package temp_pkg SHALL hold TEMP_W=8, the FSM state enum, and the alert threshold constant (50).
REQ-026 One sub-module, temp_tick_gen, SHALL generate the CLK_DIV half-period tick that FSM and sclk timing consume; everything else stays in temp_sensor_reader.

Verification
(CLK_DIV=2, SAMPLE_PERIOD=64, sensor model drives miso on sclk falling edge)
REQ-027 Sensor returns 45 (0x2D) -> cs_n low 36 cycles; temperature=45 with a 1-cycle temp_valid; the next cs_n fall occurs 64 cycles after the first.
REQ-028 Sensor returns 51, then 50, then 0xFF -> temperature reads 51, 50, 255 on successive valid pulses; the downstream alert asserts for 51 and 255 only.
REQ-029 enable deasserted during bit 3 of a frame returning 60 -> the frame completes, temperature=60, and no further cs_n fall occurs.
REQ-030 rst_n pulsed low during bit 5 -> cs_n=1, sclk=0 and temperature=0 in the same cycle, with no temp_valid; the first post-reset conversion (returning 30) yields temperature=30.
REQ-031 TEMP_AVG_EN defined, samples 48, 52, 50, 51 -> a single temp_valid after the 4th conversion with temperature=50 (201>>2); no pulses on conversions 1-3.
